// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and
// operand-forwarding select codes.
package pipeline_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_INIT       = 2'b00,
    ST_RUN        = 2'b01,
    ST_LOAD_STALL = 2'b10,
    ST_FLUSH      = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_EX  = 2'b01,
    SEL_MEM = 2'b10,
    SEL_WB  = 2'b11
  } fwd_sel_e;

  // A producer matches only if it writes a real register (x0 is never forwarded).
  function automatic logic rd_match(input logic en, input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] rs);
    return en && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_fwd_select.sv
// Per-operand forwarding mux select: picks the youngest in-flight producer
// of the source register, EX over MEM over WB.
module fwd_select
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_en_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic             mem_en_i,
  input  logic [REG_W-1:0] wb_rd_i,
  input  logic             wb_en_i,
  output logic [1:0]       sel_o
);

  always_comb begin
    sel_o = SEL_RF;
    if (rd_match(ex_en_i, ex_rd_i, rs_i))
      sel_o = SEL_EX;
    else if (rd_match(mem_en_i, mem_rd_i, rs_i))
      sel_o = SEL_MEM;
    else if (rd_match(wb_en_i, wb_rd_i, rs_i))
      sel_o = SEL_WB;
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Five-stage pipeline hazard controller: load-use stall, branch flush,
// operand forwarding selects and saturating stall/flush event counters.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] ID_RS1,
  input  logic [REG_W-1:0] ID_RS2,
  input  logic             ID_Use_RS1,
  input  logic             ID_Use_RS2,
  input  logic [REG_W-1:0] EX_RD,
  input  logic             EX_RF_Enable,
  input  logic             EX_Load_Instr,
  input  logic [REG_W-1:0] MEM_RD,
  input  logic             MEM_RF_Enable,
  input  logic [REG_W-1:0] WB_RD,
  input  logic             WB_RF_Enable,
  input  logic             Branch_Taken,
  output logic             PC_LE,
  output logic             IF_ID_LE,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic [1:0]       PA_Sel,
  output logic [1:0]       PB_Sel,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count,
  output logic [1:0]       State
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use;
  logic             stall_inc, flush_inc;
  logic             ex_fwd_en;

  assign load_use = EX_Load_Instr && EX_RF_Enable && (EX_RD != '0) &&
                    ((ID_Use_RS1 && (EX_RD == ID_RS1)) ||
                     (ID_Use_RS2 && (EX_RD == ID_RS2)));

  always_comb begin
    state_d      = ST_RUN;
    PC_LE        = 1'b1;
    IF_ID_LE     = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (state_q == ST_INIT) begin
      PC_LE        = 1'b0;
      IF_ID_LE     = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (Branch_Taken) begin
      // Redirect wins over any stall: squash both younger stages, load the target.
      state_d      = ST_FLUSH;
      IF_ID_LE     = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      flush_inc    = 1'b1;
    end else if (state_q == ST_RUN && load_use) begin
      // The stall cycle is followed by a forced RUN, so stalls never chain.
      state_d      = ST_LOAD_STALL;
      PC_LE        = 1'b0;
      IF_ID_LE     = 1'b0;
      ID_EX_Bubble = 1'b1;
      stall_inc    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_INIT;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (stall_inc && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign State       = state_q;
  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;

  // A load in EX has no data yet; that case is covered by the stall instead.
  assign ex_fwd_en = EX_RF_Enable && !EX_Load_Instr;

  fwd_select u_fwd_a (
    .rs_i     (ID_RS1),
    .ex_rd_i  (EX_RD),
    .ex_en_i  (ex_fwd_en),
    .mem_rd_i (MEM_RD),
    .mem_en_i (MEM_RF_Enable),
    .wb_rd_i  (WB_RD),
    .wb_en_i  (WB_RF_Enable),
    .sel_o    (PA_Sel)
  );

  fwd_select u_fwd_b (
    .rs_i     (ID_RS2),
    .ex_rd_i  (EX_RD),
    .ex_en_i  (ex_fwd_en),
    .mem_rd_i (MEM_RD),
    .mem_en_i (MEM_RF_Enable),
    .wb_rd_i  (WB_RD),
    .wb_en_i  (WB_RF_Enable),
    .sel_o    (PB_Sel)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller (CNT_W=4 so
// saturation is reachable in a short run).
module tb_pipeline_hazard_controller;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic Reset;
  logic [4:0] ID_RS1, ID_RS2, EX_RD, MEM_RD, WB_RD;
  logic ID_Use_RS1, ID_Use_RS2, EX_RF_Enable, EX_Load_Instr;
  logic MEM_RF_Enable, WB_RF_Enable, Branch_Taken;
  logic PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble;
  logic [1:0] PA_Sel, PB_Sel, State;
  logic [CNT_W-1:0] Stall_Count, Flush_Count;

  int passed = 0;
  int total  = 0;

  pipeline_hazard_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .Reset(Reset),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_Use_RS1(ID_Use_RS1), .ID_Use_RS2(ID_Use_RS2),
    .EX_RD(EX_RD), .EX_RF_Enable(EX_RF_Enable), .EX_Load_Instr(EX_Load_Instr),
    .MEM_RD(MEM_RD), .MEM_RF_Enable(MEM_RF_Enable),
    .WB_RD(WB_RD), .WB_RF_Enable(WB_RF_Enable),
    .Branch_Taken(Branch_Taken),
    .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble),
    .PA_Sel(PA_Sel), .PB_Sel(PB_Sel),
    .Stall_Count(Stall_Count), .Flush_Count(Flush_Count), .State(State)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    ID_RS1 = 0; ID_RS2 = 0; ID_Use_RS1 = 0; ID_Use_RS2 = 0;
    EX_RD = 0; EX_RF_Enable = 0; EX_Load_Instr = 0;
    MEM_RD = 0; MEM_RF_Enable = 0; WB_RD = 0; WB_RF_Enable = 0;
    Branch_Taken = 0;
  endtask

  // Pulse reset and return #1 after the edge that leaves INIT (state RUN).
  task automatic do_reset();
    @(negedge clk); Reset = 1'b1;
    @(negedge clk); Reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_load_hazard();
    EX_Load_Instr = 1; EX_RF_Enable = 1; EX_RD = 5; ID_RS1 = 5; ID_Use_RS1 = 1;
  endtask

  task automatic test_reset();
    clear_inputs(); Reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (State !== 2'b00) $display("FAIL rst_state: got %b want 00", State); else passed++;
    total++; if (Stall_Count !== 0 || Flush_Count !== 0) $display("FAIL rst_counters: got %0d/%0d want 0/0", Stall_Count, Flush_Count); else passed++;
    total++; if ({PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble} !== 4'b0011) $display("FAIL init_ctrl: got %b want 0011", {PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble}); else passed++;
    Reset = 1'b0; #1;
    total++; if (State !== 2'b00) $display("FAIL init_hold: got %b want 00", State); else passed++;
    @(posedge clk); #1;
    total++; if (State !== 2'b01) $display("FAIL init_to_run: got %b want 01", State); else passed++;
    total++; if ({PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble} !== 4'b1100) $display("FAIL run_ctrl: got %b want 1100", {PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble}); else passed++;
  endtask

  task automatic test_load_stall();
    set_load_hazard(); #1;
    total++; if ({PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble} !== 4'b0001) $display("FAIL stall_ctrl: got %b want 0001", {PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble}); else passed++;
    @(posedge clk); #1;
    total++; if (State !== 2'b10) $display("FAIL stall_state: got %b want 10", State); else passed++;
    total++; if (Stall_Count !== 1) $display("FAIL stall_count: got %0d want 1", Stall_Count); else passed++;
    // hazard still present in LOAD_STALL must not stall again
    total++; if ({PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble} !== 4'b1100) $display("FAIL stall_suppress: got %b want 1100", {PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble}); else passed++;
    @(posedge clk); #1;
    total++; if (State !== 2'b01 || Stall_Count !== 1) $display("FAIL stall_return: got %b/%0d want 01/1", State, Stall_Count); else passed++;
    clear_inputs();
    // RS2 hazard, then non-hazards: unused source and x0 destination
    EX_Load_Instr = 1; EX_RF_Enable = 1; EX_RD = 9; ID_RS2 = 9; ID_Use_RS2 = 1; #1;
    total++; if (PC_LE !== 1'b0) $display("FAIL stall_rs2: got %b want 0", PC_LE); else passed++;
    ID_Use_RS2 = 0; #1;
    total++; if (PC_LE !== 1'b1) $display("FAIL nostall_unused: got %b want 1", PC_LE); else passed++;
    EX_RD = 0; ID_RS2 = 0; ID_Use_RS2 = 1; #1;
    total++; if (PC_LE !== 1'b1) $display("FAIL nostall_x0: got %b want 1", PC_LE); else passed++;
    EX_Load_Instr = 0; EX_RD = 5; ID_RS2 = 5; #1;
    total++; if (PC_LE !== 1'b1) $display("FAIL nostall_alu: got %b want 1", PC_LE); else passed++;
    clear_inputs();
  endtask

  task automatic test_branch_priority();
    do_reset();
    set_load_hazard(); Branch_Taken = 1; #1;
    total++; if ({PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble} !== 4'b1011) $display("FAIL br_ctrl: got %b want 1011", {PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble}); else passed++;
    @(posedge clk); #1;
    total++; if (State !== 2'b11) $display("FAIL br_state: got %b want 11", State); else passed++;
    total++; if (Flush_Count !== 1 || Stall_Count !== 0) $display("FAIL br_counts: got %0d/%0d want 1/0", Flush_Count, Stall_Count); else passed++;
    // back-to-back branch from FLUSH
    total++; if ({PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble} !== 4'b1011) $display("FAIL br_again_ctrl: got %b want 1011", {PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble}); else passed++;
    @(posedge clk); #1;
    total++; if (State !== 2'b11 || Flush_Count !== 2) $display("FAIL br_back_to_back: got %b/%0d want 11/2", State, Flush_Count); else passed++;
    Branch_Taken = 0; #1;
    total++; if ({PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble} !== 4'b1100) $display("FAIL flush_exit_ctrl: got %b want 1100", {PC_LE, IF_ID_LE, IF_ID_Flush, ID_EX_Bubble}); else passed++;
    @(posedge clk); #1;
    total++; if (State !== 2'b01 || Stall_Count !== 0) $display("FAIL flush_exit: got %b/%0d want 01/0", State, Stall_Count); else passed++;
    clear_inputs();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    EX_RD = 7; MEM_RD = 7; WB_RD = 7; EX_RF_Enable = 1; MEM_RF_Enable = 1; WB_RF_Enable = 1;
    ID_RS2 = 7; #1;
    total++; if (PB_Sel !== 2'b01) $display("FAIL fwd_b_ex: got %b want 01", PB_Sel); else passed++;
    total++; if (PA_Sel !== 2'b00) $display("FAIL fwd_a_none: got %b want 00", PA_Sel); else passed++;
    EX_RF_Enable = 0; #1;
    total++; if (PB_Sel !== 2'b10) $display("FAIL fwd_b_mem: got %b want 10", PB_Sel); else passed++;
    MEM_RF_Enable = 0; #1;
    total++; if (PB_Sel !== 2'b11) $display("FAIL fwd_b_wb: got %b want 11", PB_Sel); else passed++;
    ID_RS2 = 0; #1;
    total++; if (PB_Sel !== 2'b00) $display("FAIL fwd_b_rs0: got %b want 00", PB_Sel); else passed++;
    // loaded value in EX is not forwardable; MEM copy is used instead
    EX_RF_Enable = 1; EX_Load_Instr = 1; MEM_RF_Enable = 1; ID_RS1 = 7; #1;
    total++; if (PA_Sel !== 2'b10) $display("FAIL fwd_a_load_skip: got %b want 10", PA_Sel); else passed++;
    EX_RD = 0; MEM_RD = 0; WB_RD = 0; EX_Load_Instr = 0; ID_RS1 = 0; #1;
    total++; if (PA_Sel !== 2'b00) $display("FAIL fwd_a_x0: got %b want 00", PA_Sel); else passed++;
    EX_RD = 3; MEM_RD = 4; WB_RD = 4; ID_RS1 = 4; ID_RS2 = 3; #1;
    total++; if (PA_Sel !== 2'b10 || PB_Sel !== 2'b01) $display("FAIL fwd_mixed: got %b/%b want 10/01", PA_Sel, PB_Sel); else passed++;
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_hazard();
    repeat (40) @(posedge clk);
    #1;
    total++; if (Stall_Count !== 4'd15) $display("FAIL stall_saturate: got %0d want 15", Stall_Count); else passed++;
    clear_inputs(); Branch_Taken = 1;
    repeat (20) @(posedge clk);
    #1;
    total++; if (Flush_Count !== 4'd15 || Stall_Count !== 4'd15) $display("FAIL flush_saturate: got %0d/%0d want 15/15", Flush_Count, Stall_Count); else passed++;
    clear_inputs();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_load_hazard();
    @(posedge clk); #1;
    total++; if (State !== 2'b10 || Stall_Count !== 1) $display("FAIL pre_abort: got %b/%0d want 10/1", State, Stall_Count); else passed++;
    #1 Reset = 1'b1; #1;
    total++; if (State !== 2'b00 || Stall_Count !== 0 || Flush_Count !== 0) $display("FAIL async_abort: got %b/%0d/%0d want 00/0/0", State, Stall_Count, Flush_Count); else passed++;
    @(negedge clk); Reset = 1'b0; clear_inputs();
    @(posedge clk); #1;
    total++; if (State !== 2'b01) $display("FAIL abort_recover: got %b want 01", State); else passed++;
  endtask

  initial begin
    test_reset();
    test_load_stall();
    test_branch_priority();
    test_forwarding();
    test_saturation();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall and flush event counters.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 ID_RS1, ID_RS2  in  5 each  source registers of the instruction in the IF/ID stage.
REQ-005 ID_Use_RS1, ID_Use_RS2  in  1 each  high when the ID instruction actually reads RS1 / RS2.
REQ-006 EX_RD  in  5; EX_RF_Enable  in  1; EX_Load_Instr  in  1  destination and flags of the ID/EX stage instruction.
REQ-007 MEM_RD  in  5; MEM_RF_Enable  in  1  destination and flag of the EX/MEM stage instruction.
REQ-008 WB_RD  in  5; WB_RF_Enable  in  1  destination and flag of the MEM/WB stage instruction.
REQ-009 Branch_Taken  in  1  taken branch, JAL or JALR resolved in EX this cycle.
REQ-010 PC_LE  out  1  PC load enable.
REQ-011 IF_ID_LE  out  1  IF/ID load enable.
REQ-012 IF_ID_Flush  out  1  drives IF/ID Inconditional_Reset.
REQ-013 ID_EX_Bubble  out  1  drives ID/EX Conditional_Reset.
REQ-014 PA_Sel, PB_Sel  out  2 each  operand source: 00 register file, 01 EX, 10 MEM, 11 WB.
REQ-015 Stall_Count, Flush_Count  out  CNT_W each  event counters.
REQ-016 State  out  2  current FSM state, for debug.

Function
REQ-017 The FSM SHALL have four states: INIT=00, RUN=01, LOAD_STALL=10, FLUSH=11.
REQ-018 INIT SHALL drive PC_LE=0, IF_ID_LE=0, IF_ID_Flush=1 and ID_EX_Bubble=1, and SHALL always go to RUN on the next edge.
REQ-019 A load-use hazard SHALL be EX_Load_Instr & EX_RF_Enable & EX_RD!=0 & ((ID_Use_RS1 & EX_RD==ID_RS1) | (ID_Use_RS2 & EX_RD==ID_RS2)).
REQ-020 In RUN or LOAD_STALL with Branch_Taken=1, the block SHALL assert IF_ID_Flush=1, ID_EX_Bubble=1, PC_LE=1 and IF_ID_LE=0, then go to FLUSH.
REQ-021 Branch_Taken SHALL have priority over a simultaneous load-use hazard; no stall is counted in that cycle.
REQ-022 In RUN with a load-use hazard and no Branch_Taken, the block SHALL assert PC_LE=0, IF_ID_LE=0, ID_EX_Bubble=1 and IF_ID_Flush=0, then go to LOAD_STALL.
REQ-023 In RUN with no event, and in LOAD_STALL or FLUSH with no branch, the block SHALL drive PC_LE=1, IF_ID_LE=1 and both clears 0, then go to RUN.
REQ-024 In LOAD_STALL and FLUSH, load-use detection SHALL be suppressed, so back-to-back stalls cannot occur.
REQ-025 In FLUSH with Branch_Taken=1, the block SHALL act as REQ-020 (the branch is ignored only if it comes from a bubble, which is upstream's duty).
REQ-026 All control outputs SHALL be combinational from the current state and inputs, taking effect at the next posedge.
REQ-027 PA_Sel SHALL be 01 when EX_RF_Enable & !EX_Load_Instr & EX_RD!=0 & EX_RD==ID_RS1.
REQ-028 Otherwise PA_Sel SHALL be 10 on a MEM match (MEM_RF_Enable, MEM_RD!=0), else 11 on a WB match, else 00; PB_Sel SHALL use ID_RS2 the same way.
REQ-029 Forwarding priority SHALL be EX > MEM > WB; register x0 SHALL never be forwarded.
REQ-030 Stall_Count SHALL increment by 1 on each edge that leaves RUN for LOAD_STALL.
REQ-031 Flush_Count SHALL increment by 1 on each edge that enters FLUSH.
REQ-032 Both counters SHALL saturate at all-ones and SHALL not wrap.

Reset
REQ-033 While Reset=1, state SHALL be INIT and both counters 0, applied asynchronously.
REQ-034 After Reset, INIT SHALL last exactly one clock after deassertion, then RUN.
REQ-035 Asserting Reset mid-stall or mid-flush SHALL abort the sequence immediately with no counter update.

Structure
REQ-036 State encodings and PA/PB select codes SHALL live in a shared package (pipeline_ctrl_pkg).
REQ-037 One sub-module, fwd_select, SHALL compute a single 2-bit select; it SHALL be instantiated twice, once for RS1 and once for RS2.

Verification
REQ-038 Reset released -> INIT for 1 cycle (PC_LE=0, both clears=1) -> RUN with PC_LE=1 and IF_ID_LE=1.
REQ-039 EX_Load_Instr=1, EX_RD=5, ID_RS1=5, ID_Use_RS1=1 -> one cycle of PC_LE=0, IF_ID_LE=0, ID_EX_Bubble=1; next cycle RUN; Stall_Count=1.
REQ-040 Branch_Taken=1 together with the REQ-039 hazard -> IF_ID_Flush=1, ID_EX_Bubble=1, PC_LE=1; Flush_Count=1, Stall_Count=0.
REQ-041 EX_RD=MEM_RD=WB_RD=7, all RF enables=1, ID_RS2=7 -> PB_Sel=01; drop EX_RF_Enable -> 10; drop MEM_RF_Enable -> 11; ID_RS2=0 -> 00.
REQ-042 CNT_W=4 with 20 load-use stalls -> Stall_Count holds at 15.
REQ-043 Reset asserted during LOAD_STALL -> State=INIT immediately and counters=0.
